seq_mul_ctrl: RTL and testbench
===============================

// Module: seq_mul_ctrl
// PURPOSE
//  Sequencing controller for the 16-bit arithmetic unit. It accepts add, sub and
//  multiply requests over a valid/ready handshake. Add and sub run on one shared
//  WIDTH-bit add/sub adder. Multiply reuses that same adder iteratively
//  (shift-add, one partial product per cycle), which replaces the 15-adder array.
//  The result is held until the consumer accepts it.
// PARAMETERS
//  WIDTH    16   operand width; must be >= 2; result is 2*WIDTH bits
//  CNT_W    5    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous reset, active-low
//  in_valid   in   1        request valid
//  in_ready   out  1        controller can accept (high only in IDLE)
//  inputA     in   WIDTH    operand A (augend / minuend / multiplicand)
//  inputB     in   WIDTH    operand B (addend / subtrahend / multiplier)
//  mode       in   2        00 add, 01 sub, 10 mul (unsigned), 11 illegal
//  out_valid  out  1        result valid (high only in DONE)
//  out_ready  in   1        consumer accepts result
//  result     out  2*WIDTH  add/sub: {WIDTH'b0, sum}; mul: full product
//  carry      out  1        add/sub carry-out (sub: 1 = no borrow); mul: 0
//  overflow   out  1        add/sub: signed overflow (c[W]^c[W-1]); mul: |result[2W-1:W]
//  err        out  1        1 when the completed request had mode==11
//  busy       out  1        high in RUN
// BEHAVIOUR
//  - Reset (rst_n==0 at a clk edge): state=IDLE; result, carry, overflow, err,
//    out_valid, busy <= 0; in_ready=1 after the edge.
//  - Reset mid-operation aborts immediately. The partial result is discarded
//    and no out_valid is produced.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    - IDLE: in_valid&in_ready at the edge latches A, B, mode; go to RUN.
//    - RUN: add/sub/illegal spend 1 cycle. mul spends WIDTH cycles (counter
//      0..WIDTH-1). Then go to DONE with the result registered.
//    - DONE: out_valid=1; outputs stay stable while out_ready=0. out_valid&out_ready
//      at the edge returns to IDLE.
//  - Handshake:
//    - No new request is accepted in the same cycle as the result handoff.
//    - in_valid during RUN/DONE is ignored (in_ready=0).
//    - Inputs are sampled only on the accept edge.
//  - Latency, accept edge = edge 0:
//    - add/sub: out_valid high after edge 2.
//    - mul: out_valid high after edge WIDTH+1 (17 at default).
//  - add/sub: B is XORed with mode[0] and carry-in = mode[0], so sub = A + ~B + 1.
//    Sum is WIDTH bits and wraps modulo 2**WIDTH.
//  - mul datapath: acc[WIDTH:0] and mplr[WIDTH-1:0].
//    - Each RUN cycle: if mplr[0], acc = acc[W-1:0] + A, else acc unchanged.
//    - Then {acc,mplr} >>= 1.
//    - Final result = {acc[W-1:0], mplr}.
//  - Illegal mode 11: result=0, carry=0, overflow=0, err=1; completes as add/sub
//    timing.
//  - Simultaneous in_valid with reset: reset wins.
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined: a mul whose latched A==0 or B==0 takes 1 RUN cycle,
//    with result=0, overflow=0 (same latency as add).
//  MUL_EARLY_EXIT_EN undefined: every mul takes exactly WIDTH RUN cycles,
//    whatever the operands.
// TESTING
//  1 mul 0x0002*0x0002, out_ready=1 -> result=0x00000004, overflow=0, out_valid
//    at edge 17.
//  2 mul 0xFFFF*0xFFFF -> result=0xFFFE0001, overflow=1, carry=0, err=0.
//  3 add 0x7FFF+0x0001 -> result=0x00008000, carry=0, overflow=1, at edge 2.
//    sub 0x0005-0x0005 -> result=0, carry=1, overflow=0.
//  4 out_ready=0 for 5 cycles after mul 0x1234*0x0010 -> result=0x00012340 held
//    stable; in_ready=0 and a second in_valid is ignored; release returns to IDLE.
//  5 rst_n=0 at edge 8 of a mul -> next cycle in_ready=1, out_valid=0, result=0.
//    A following add 1+2 gives result=3.
//  6 mul 0x0000*0x1234 -> result=0, out_valid at edge 2 with MUL_EARLY_EXIT_EN,
//    edge 17 without. mode=11 -> err=1, result=0.

Source files
------------

// File: rtl/seq_mul_ctrl.sv
// Sequencing controller: add/sub on one shared adder, unsigned multiply by iterative shift-add on that same adder.
// Optional feature macro MUL_EARLY_EXIT_EN: a multiply with a zero operand finishes after a single RUN step.
module seq_mul_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   inputA,
   input  logic [WIDTH-1:0]   inputB,
   input  logic [1:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               carry,
   output logic               overflow,
   output logic               err,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] mplr;
   logic [1:0]       mode_q;
   logic [WIDTH:0]   acc;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt;
   logic             skip;

   logic             is_mul;
   logic [CNT_W-1:0] n_ops;
   logic             last;
   logic [WIDTH-1:0] opa, opb;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   step;
   logic             accept;

   // Signed overflow: carry out of the MSB differs from carry into the MSB.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                    input logic [WIDTH:0] s);
      add_ovf = s[WIDTH] ^ (a_msb ^ b_msb ^ s[WIDTH-1]);
   endfunction

   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign is_mul   = (mode_q == 2'b10);
   assign n_ops    = (is_mul && !skip) ? CNT_MUL : CNT_ONE;
   // The cycle after the last compute step writes the result registers.
   assign last     = (cnt == n_ops);

   // One shared adder: sub folds into add via inverted B and carry-in.
   assign opa  = is_mul ? acc[WIDTH-1:0] : a_q;
   assign opb  = is_mul ? a_q : (mplr ^ {WIDTH{mode_q[0]}});
   assign cin  = is_mul ? 1'b0 : mode_q[0];
   assign sum  = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
   assign step = mplr[0] ? sum : acc;

`ifdef MUL_EARLY_EXIT_EN
   logic skip_q;
   always_ff @(posedge clk) begin
      if (accept)
         skip_q <= (mode == 2'b10) && ((inputA == '0) || (inputB == '0));
   end
   assign skip = skip_q;
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (in_valid) state_nx = S_RUN;
         S_RUN:   if (last) state_nx = S_DONE;
         S_DONE:  if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         out_valid <= (state_nx == S_DONE);
         busy      <= (state_nx == S_RUN);
         if (state == S_RUN && last) begin
            case (mode_q)
               2'b10: begin
                  result   <= {acc[WIDTH-1:0], mplr};
                  carry    <= 1'b0;
                  overflow <= |acc[WIDTH-1:0];
                  err      <= 1'b0;
               end
               2'b11: begin
                  result   <= '0;
                  carry    <= 1'b0;
                  overflow <= 1'b0;
                  err      <= 1'b1;
               end
               default: begin
                  result   <= {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
                  carry    <= acc[WIDTH];
                  overflow <= ovf_q;
                  err      <= 1'b0;
               end
            endcase
         end
      end
   end

   // Operand and working registers carry no reset; they are loaded on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q    <= inputA;
         mplr   <= inputB;
         mode_q <= mode;
         acc    <= '0;
         ovf_q  <= 1'b0;
         cnt    <= '0;
      end else if (state == S_RUN && !last) begin
         cnt <= cnt + CNT_ONE;
         if (is_mul) begin
            if (skip) begin
               acc  <= '0;
               mplr <= '0;
            end else begin
               acc  <= {1'b0, step[WIDTH:1]};
               mplr <= {step[0], mplr[WIDTH-1:1]};
            end
         end else begin
            acc   <= sum;
            ovf_q <= add_ovf(opa[WIDTH-1], opb[WIDTH-1], sum);
         end
      end
   end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Scoreboard bench for seq_mul_ctrl: directed requests push expected results, a monitor checks each output.
module tb_seq_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] inputA = '0;
   logic [15:0] inputB = '0;
   logic [1:0]  mode = 2'b00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        carry, overflow, err, busy;

   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        o;
      logic        e;
      int          exp_edge;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic prev_v = 1'b0;
   int   dummy;

`ifdef MUL_EARLY_EXIT_EN
   localparam int LAT_MUL0 = 2;
`else
   localparam int LAT_MUL0 = 17;
`endif

   seq_mul_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .inputA(inputA), .inputB(inputB), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .carry(carry),
      .overflow(overflow), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: compares every cycle the result is presented, so a hold is also checked for stability.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            if (!prev_v) check("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            if (!prev_v) check("latency_edge", cyc, sb[0].exp_edge);
            check("result", result, sb[0].res);
            check("carry", 32'(carry), 32'(sb[0].c));
            check("overflow", 32'(overflow), 32'(sb[0].o));
            check("err", 32'(err), 32'(sb[0].e));
            if (out_ready) sb.pop_front();
         end
      end
      prev_v <= out_valid;
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                        input logic [31:0] r, input logic c, input logic o, input logic e,
                        input int lat, input bit push, output int acc_edge);
      exp_t x;
      int   t;
      acc_edge = -1;
      @(posedge clk); #1;
      in_valid = 1'b1; inputA = a; inputB = b; mode = m;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 200) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      acc_edge = cyc;
      if (push) begin
         x.res = r; x.c = c; x.o = o; x.e = e; x.exp_edge = acc_edge + lat;
         sb.push_back(x);
      end
      in_valid = 1'b0;
      inputA = ~a; inputB = ~b; mode = ~m;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 || !in_ready) begin
         @(negedge clk);
         t++;
         if (t > 300) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            return;
         end
      end
   endtask

   initial begin
      int ae;
      int t;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;

      // Multiply and add/sub corner cases
      issue(16'h0002, 16'h0002, 2'b10, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 17, 1'b1, dummy);
      wait_drain();
      issue(16'hFFFF, 16'hFFFF, 2'b10, 32'hFFFE_0001, 1'b0, 1'b1, 1'b0, 17, 1'b1, dummy);
      wait_drain();
      issue(16'h7FFF, 16'h0001, 2'b00, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 2, 1'b1, dummy);
      wait_drain();
      issue(16'h0005, 16'h0005, 2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2, 1'b1, dummy);
      wait_drain();
      issue(16'h0000, 16'h0001, 2'b01, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 2, 1'b1, dummy);
      wait_drain();
      issue(16'h8000, 16'h0001, 2'b01, 32'h0000_7FFF, 1'b1, 1'b1, 1'b0, 2, 1'b1, dummy);
      wait_drain();
      issue(16'hFFFF, 16'h0001, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2, 1'b1, dummy);
      wait_drain();
      issue(16'h00FF, 16'h0101, 2'b10, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 17, 1'b1, dummy);
      wait_drain();
      issue(16'h8000, 16'h0002, 2'b10, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 17, 1'b1, dummy);
      wait_drain();

      // Back-pressure: result held, in_ready low and a new request ignored
      out_ready = 1'b0;
      issue(16'h1234, 16'h0010, 2'b10, 32'h0001_2340, 1'b0, 1'b1, 1'b0, 17, 1'b1, dummy);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("hold_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; inputA = 16'h0009; inputB = 16'h0009; mode = 2'b00;
         @(negedge clk);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain();
      repeat (4) @(negedge clk);
      check("release_idle", 32'(in_ready), 32'd1);

      // Reset in the middle of a multiply aborts it
      issue(16'h00AB, 16'h00CD, 2'b10, 32'h0, 1'b0, 1'b0, 1'b0, 17, 1'b0, ae);
      while (cyc < ae + 7) @(posedge clk);
      #1;
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      issue(16'h0001, 16'h0002, 2'b00, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 2, 1'b1, dummy);
      wait_drain();

      // Zero-operand multiply and illegal mode
      issue(16'h0000, 16'h1234, 2'b10, 32'h0, 1'b0, 1'b0, 1'b0, LAT_MUL0, 1'b1, dummy);
      wait_drain();
      issue(16'h0005, 16'h0006, 2'b11, 32'h0, 1'b0, 1'b0, 1'b1, 2, 1'b1, dummy);
      wait_drain();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
